// File: rtl/sort_stream.sv
// Streaming frame sorter: loads N elements, runs N odd-even transposition phases, then streams them out.
// Optional macro SORT_DESCEND_EN selects descending order; the default build sorts ascending.
module sort_stream #(
  parameter int N = 6,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, idx_q, phase_q;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  sorted_d [N];
  logic [CW-1:0] idx_d;
  logic          in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [W-1:0]  out_data_q;

  // Pairs of one phase are disjoint, so updating sorted_d in place never reads a value already moved this phase.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) sorted_d[i] = mem_q[i];
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (i[0] == phase_q[0]) begin
`ifdef SORT_DESCEND_EN
        if (sorted_d[i] < sorted_d[i+1]) begin
`else
        if (sorted_d[i] > sorted_d[i+1]) begin
`endif
          sorted_d[i]   = mem_q[i+1];
          sorted_d[i+1] = mem_q[i];
        end
      end
    end
    idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      phase_q     <= '0;
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            mem_q[cnt_q] <= in_data;
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              phase_q    <= '0;
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SORT: begin
          for (int unsigned i = 0; i < N; i++) mem_q[i] <= sorted_d[i];
          if (phase_q == LAST) begin
            phase_q     <= '0;
            idx_q       <= '0;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= sorted_d[0];
            out_last_q  <= (LAST == '0);
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (idx_q == LAST) begin
              idx_q       <= '0;
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q      <= idx_d;
              out_data_q <= mem_q[idx_d];
              out_last_q <= (idx_d == LAST);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: directed vector table, reset corner cases, and random frames vs. a queue-sort model.
module tb_sort_stream;
  localparam int N = 6;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic in_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;

  sort_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int t_last = 0;

  typedef struct {
    int din[N];
    int exp[N];
    int mode;
    bit garbage;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic orient(input int asc[N], output int e[N]);
    for (int k = 0; k < N; k++) begin
`ifdef SORT_DESCEND_EN
      e[k] = asc[N-1-k];
`else
      e[k] = asc[k];
`endif
    end
  endtask

  task automatic load_elems(input int d[N], input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      in_valid = 1'b1;
      in_data  = W'(d[k]);
      for (int w = 0; w < 100 && !in_ready; w++) step();
      chk("load_ready", in_ready, 1);
      t_last = cyc;
      step();
    end
    in_valid = 1'b0;
  endtask

  // mode: 0 always ready, 1 ready on every third valid cycle, 2 random
  task automatic collect(input int e[N], input int mode, input bit garbage);
    int k = 0;
    int v = 0;
    bit stalled = 0;
    int prev_d = 0;
    int prev_l = 0;
    for (int n = 0; n < 500 && k < N; n++) begin
      if (garbage) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
      end
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (v % 3 == 0) : 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (v == 0) chk("latency", cyc - t_last, N + 1);
        if (stalled) begin
          chk("stall_data", out_data, prev_d);
          chk("stall_last", out_last, prev_l);
        end
        chk("in_ready_out", in_ready, 0);
        chk("busy_out", busy, 1);
        if (out_ready) begin
          chk("data", out_data, e[k]);
          chk("last", out_last, (k == N - 1));
          if (k == N - 1) in_valid = 1'b0;
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev_d = out_data;
          prev_l = out_last;
        end
        v++;
      end else begin
        chk("busy_sort", busy, 1);
        if (v > 0) chk("valid_drop", out_valid, 1);
      end
      step();
    end
    chk("collect_count", k, N);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_valid", out_valid, 0);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_valid"}, out_valid, 0);
    chk({tag, "_rst_last"}, out_last, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_data"}, out_data, 0);
    step();
    rst = 1'b0;
    step();
    chk({tag, "_rst_in_ready"}, in_ready, 1);
  endtask

  int e[N];
  int f[N];
  int q[$];

  initial begin
    vt[0] = '{din: '{13, 8, 9, 0, 9, 12},   exp: '{0, 8, 9, 9, 12, 13},   mode: 0, garbage: 0};
    vt[1] = '{din: '{6, 5, 4, 3, 2, 1},     exp: '{1, 2, 3, 4, 5, 6},     mode: 0, garbage: 0};
    vt[2] = '{din: '{1, 2, 3, 4, 5, 6},     exp: '{1, 2, 3, 4, 5, 6},     mode: 0, garbage: 0};
    vt[3] = '{din: '{8, 21, 3, 20, 19, 5},  exp: '{3, 5, 8, 19, 20, 21},  mode: 1, garbage: 0};
    vt[4] = '{din: '{9, 6, 16, 3, 20, 16},  exp: '{3, 6, 9, 16, 16, 20},  mode: 0, garbage: 1};
    vt[5] = '{din: '{2, 4, 6, 5, 1, 3},     exp: '{1, 2, 3, 4, 5, 6},     mode: 2, garbage: 1};
    vt[6] = '{din: '{31, 0, 31, 0, 17, 0},  exp: '{0, 0, 0, 17, 31, 31},  mode: 0, garbage: 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_in_ready", in_ready, 1);

    foreach (vt[i]) begin
      orient(vt[i].exp, e);
      load_elems(vt[i].din, N, 1'b0);
      collect(e, vt[i].mode, vt[i].garbage);
    end

    // Reset after three inputs, then a full frame must start from element 0.
    f = '{2, 4, 6, 5, 1, 3};
    orient('{1, 2, 3, 4, 5, 6}, e);
    load_elems(f, 3, 1'b0);
    reset_check("midload");
    load_elems(f, N, 1'b0);
    collect(e, 0, 1'b0);

    // Reset while presenting element idx=2.
    load_elems(f, N, 1'b0);
    out_ready = 1'b1;
    for (int w = 0; w < 50 && !out_valid; w++) step();
    chk("out_valid_wait", out_valid, 1);
    step();
    step();
    chk("idx2_data", out_data, e[2]);
    reset_check("midout");
    out_ready = 1'b0;
    load_elems(f, N, 1'b0);
    collect(e, 0, 1'b0);

    // Reset in the middle of sorting.
    load_elems(vt[0].din, N, 1'b0);
    repeat (3) step();
    reset_check("midsort");
    load_elems(f, N, 1'b0);
    collect(e, 0, 1'b0);

    // Partial frame waits with in_valid low.
    load_elems(vt[1].din, 2, 1'b0);
    repeat (20) step();
    chk("partial_in_ready", in_ready, 1);
    chk("partial_busy", busy, 0);
    for (int k = 2; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = W'(vt[1].din[k]);
      t_last = cyc;
      step();
    end
    in_valid = 1'b0;
    orient(vt[1].exp, e);
    collect(e, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      q.delete();
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 5))
          0: f[k] = 0;
          1: f[k] = (1 << W) - 1;
          default: f[k] = int'($urandom_range(0, (1 << W) - 1));
        endcase
        q.push_back(f[k]);
      end
`ifdef SORT_DESCEND_EN
      q.rsort();
`else
      q.sort();
`endif
      for (int k = 0; k < N; k++) e[k] = q[k];
      load_elems(f, N, 1'b1);
      collect(e, 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
